// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes: captures a 128-bit state, substitutes LANES bytes
// per cycle through the inverse S-box, then holds the result until taken.
module inv_sub_bytes_seq #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);

   // state | meaning
   // IDLE  | waiting for a block, in_ready=1
   // BUSY  | substituting group grp of the working register
   // DONE  | result valid on out_data, waiting for out_ready
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam int NGROUPS = 16 / LANES;
   localparam int GW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
   localparam logic [GW-1:0] LAST_G = GW'(NGROUPS - 1);

   // Entry for byte value b sits at bits [2047-8b -: 8]
   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX[11'd2047 - {b, 3'b000} -: 8];
   endfunction

   state_t         state;
   state_t         state_nxt;
   logic [GW-1:0]  grp;
   logic [127:0]   work;
   logic [127:0]   work_sub;

   always_comb begin
      work_sub = work;
      for (int l = 0; l < LANES; l++) begin
         work_sub[127 - 8*(int'(grp)*LANES + l) -: 8] =
            inv_sbox(work[127 - 8*(int'(grp)*LANES + l) -: 8]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         grp   <= '0;
         work  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work <= state_in;
                  grp  <= '0;
               end
            end
            BUSY: begin
               work <= work_sub;
               grp  <= (grp == LAST_G) ? '0 : grp + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = BUSY;
         BUSY:    if (grp == LAST_G) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE:    in_ready  = 1'b1;
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   assign out_data = work;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: LANES=4 and LANES=1 instances, expected values
// from an inverse S-box derived arithmetically (GF(2^8) inverse of inverse affine).
module tb_inv_sub_bytes_seq;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [127:0] state_in, out_data;
   logic         in_valid1, in_ready1, out_valid1, out_ready1;
   logic [127:0] state_in1, out_data1;

   int           n_checks = 0;
   int           n_pass   = 0;
   logic [7:0]   isb [256];
   logic [127:0] exp_q [$];

   localparam logic [127:0] FIPS_IN  = 128'h637C777BF26B6FC53001672BFED7AB76;
   localparam logic [127:0] FIPS_OUT = 128'h000102030405060708090A0B0C0D0E0F;

   always #5 clk = ~clk;

   inv_sub_bytes_seq #(.LANES(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .state_in(state_in), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data)
   );

   inv_sub_bytes_seq #(.LANES(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .state_in(state_in1), .out_valid(out_valid1), .out_ready(out_ready1),
      .out_data(out_data1)
   );

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic logic [127:0] model(input logic [127:0] d);
      logic [127:0] r;
      r = '0;
      for (int k = 0; k < 16; k++) r[127-8*k -: 8] = isb[d[127-8*k -: 8]];
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic build_model();
      logic [7:0] t;
      for (int s = 0; s < 256; s++) begin
         t = rotl(8'(s), 1) ^ rotl(8'(s), 3) ^ rotl(8'(s), 6) ^ 8'h05;
         isb[s] = 8'h00;
         if (t != 8'h00)
            for (int y = 1; y < 256; y++)
               if (gmul(t, 8'(y)) == 8'h01) isb[s] = 8'(y);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic put_block(input logic [127:0] d, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (in_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (ok) begin
         in_valid = 1'b1;
         state_in = d;
         exp_q.push_back(model(d));
         @(negedge clk);
         in_valid = 1'b0;
         state_in = rnd128();
      end
   endtask

   task automatic wait_out(output int edges, output bit ok);
      edges = 0;
      ok    = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) begin ok = 1'b1; break; end
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; state_in = '0;
      in_valid1 = 1'b0; out_ready1 = 1'b0; state_in1 = '0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, out_data} !== {2'b10, 128'h0})
         $display("FAIL reset_during: rdy=%b vld=%b data=%h expected rdy=1 vld=0 data=0",
                  in_ready, out_valid, out_data);
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, out_data} !== {2'b10, 128'h0})
         $display("FAIL reset_after: rdy=%b vld=%b data=%h expected rdy=1 vld=0 data=0",
                  in_ready, out_valid, out_data);
      else n_pass++;
   endtask

   task automatic test_fips_latency();
      bit ok, ok2; int edges; logic [127:0] exp;
      put_block(FIPS_IN, ok);
      wait_out(edges, ok2);
      n_checks++;
      if (!(ok && ok2)) $display("FAIL fips_timeout: accept=%b done=%b expected 1 1", ok, ok2);
      else n_pass++;
      n_checks++;
      if (edges !== 4) $display("FAIL fips_latency: %0d edges expected 4", edges);
      else n_pass++;
      exp = exp_q.pop_front();
      n_checks++;
      if (out_data !== FIPS_OUT || out_data !== exp)
         $display("FAIL fips_data: got %h expected %h", out_data, FIPS_OUT);
      else n_pass++;
      handshake();
      n_checks++;
      if ({in_ready, out_valid} !== 2'b10 || out_data !== FIPS_OUT)
         $display("FAIL fips_retain: rdy=%b vld=%b data=%h expected 1 0 %h",
                  in_ready, out_valid, out_data, FIPS_OUT);
      else n_pass++;
   endtask

   task automatic test_spot();
      bit ok, ok2; int edges; logic [127:0] exp;
      put_block(128'h63D410160A00FF000000000000000000, ok);
      wait_out(edges, ok2);
      exp = exp_q.pop_front();
      n_checks++;
      if (!(ok && ok2) || out_data !== 128'h00197CFFA3527D525252525252525252)
         $display("FAIL spot_const: got %h expected %h", out_data,
                  128'h00197CFFA3527D525252525252525252);
      else n_pass++;
      n_checks++;
      if (out_data !== exp) $display("FAIL spot_model: got %h expected %h", out_data, exp);
      else n_pass++;
      handshake();
   endtask

   task automatic test_random();
      bit ok, ok2; int edges; logic [127:0] exp;
      for (int n = 0; n < 6; n++) begin
         put_block(rnd128(), ok);
         wait_out(edges, ok2);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         exp = exp_q.pop_front();
         n_checks++;
         if (!(ok && ok2) || out_data !== exp || edges !== 4)
            $display("FAIL random_%0d: got %h lat %0d expected %h lat 4", n, out_data, edges, exp);
         else n_pass++;
         handshake();
      end
   endtask

   task automatic test_back_to_back();
      bit ok, ok2; int edges; logic [127:0] nxt, exp;
      put_block(rnd128(), ok);
      wait_out(edges, ok2);
      nxt       = rnd128();
      in_valid  = 1'b1;
      state_in  = nxt;
      out_ready = 1'b1;
      exp = exp_q.pop_front();
      n_checks++;
      if (!(ok && ok2) || out_data !== exp)
         $display("FAIL b2b_first: got %h expected %h", out_data, exp);
      else n_pass++;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || out_data !== exp)
         $display("FAIL b2b_idle: rdy=%b data=%h expected 1 %h", in_ready, out_data, exp);
      else n_pass++;
      exp_q.push_back(model(nxt));
      @(negedge clk);
      in_valid = 1'b0;
      state_in = rnd128();
      wait_out(edges, ok2);
      exp = exp_q.pop_front();
      n_checks++;
      if (!ok2 || out_data !== exp || edges !== 4)
         $display("FAIL b2b_second: got %h lat %0d expected %h lat 4", out_data, edges, exp);
      else n_pass++;
      handshake();
   endtask

   task automatic test_backpressure();
      bit ok, ok2; int edges; int bad; logic [127:0] exp;
      put_block(rnd128(), ok);
      wait_out(edges, ok2);
      exp = exp_q.pop_front();
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         in_valid = ~in_valid;
         state_in = rnd128();
         @(negedge clk);
         if (out_data !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
      end
      n_checks++;
      if (!(ok && ok2) || bad !== 0)
         $display("FAIL backpressure: %0d bad cycles, data=%h expected 0 bad, data %h",
                  bad, out_data, exp);
      else n_pass++;
      in_valid = 1'b0;
      handshake();
      n_checks++;
      if ({in_ready, out_valid} !== 2'b10 || out_data !== exp)
         $display("FAIL bp_no_capture: rdy=%b vld=%b data=%h expected 1 0 %h",
                  in_ready, out_valid, out_data, exp);
      else n_pass++;
   endtask

   task automatic test_mid_reset();
      bit ok, ok2; int edges; int seen;
      put_block(rnd128(), ok);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, out_data} !== {2'b10, 128'h0})
         $display("FAIL midrst_state: rdy=%b vld=%b data=%h expected 1 0 0",
                  in_ready, out_valid, out_data);
      else n_pass++;
      rst  = 1'b0;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) seen++;
      end
      n_checks++;
      if (!ok || seen !== 0) $display("FAIL midrst_no_valid: %0d valid cycles expected 0", seen);
      else n_pass++;
      put_block({16{8'h63}}, ok);
      wait_out(edges, ok2);
      void'(exp_q.pop_front());
      n_checks++;
      if (!(ok && ok2) || out_data !== 128'h0)
         $display("FAIL midrst_after: got %h expected 0", out_data);
      else n_pass++;
      handshake();
   endtask

   task automatic test_lanes1();
      bit ok; int edges;
      n_checks++;
      if (in_ready1 !== 1'b1) $display("FAIL l1_ready: got %b expected 1", in_ready1);
      else n_pass++;
      in_valid1 = 1'b1;
      state_in1 = FIPS_IN;
      @(negedge clk);
      in_valid1 = 1'b0;
      state_in1 = rnd128();
      edges = 0; ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid1) begin ok = 1'b1; break; end
         @(negedge clk);
         edges++;
      end
      n_checks++;
      if (!ok || edges !== 16) $display("FAIL l1_latency: %0d edges expected 16", edges);
      else n_pass++;
      n_checks++;
      if (out_data1 !== FIPS_OUT) $display("FAIL l1_data: got %h expected %h", out_data1, FIPS_OUT);
      else n_pass++;
      out_ready1 = 1'b1;
      @(negedge clk);
      out_ready1 = 1'b0;
      n_checks++;
      if (out_valid1 !== 1'b0) $display("FAIL l1_release: vld=%b expected 0", out_valid1);
      else n_pass++;
   endtask

   initial begin
      rst = 1'b1;
      build_model();
      test_reset();
      test_fips_latency();
      test_spot();
      test_random();
      test_back_to_back();
      test_backpressure();
      test_mid_reset();
      test_lanes1();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
